// File: rtl/fmul_share_ctrl.sv
// rtl/fmul_share_ctrl.sv - round-robin sequencer sharing one multi-cycle float multiplier
//
// Purpose: arbitrates N_REQ operand requesters onto a single multiplier, issues a
// one-cycle start pulse, waits for done (or aborts after TIMEOUT cycles) and returns
// the result tagged with the owning requester index.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready[N_REQ]      per-requester operand handshake (ready one-hot or zero)
//   req_a/req_b[32*N_REQ]           packed operands, requester i at [32i+31:32i]
//   mul_start, mul_a, mul_b         start pulse and held operands to the multiplier
//   mul_done, mul_c, mul_err        completion pulse, result and overflow flag
//   rsp_valid/rsp_ready             response handshake
//   rsp_id, rsp_c, rsp_err, rsp_timeout  response payload

module fmul_share_ctrl #(
   parameter int  N_REQ   = 4,
   parameter int  TIMEOUT = 63,
   localparam int IDW     = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [32*N_REQ-1:0]  req_a,
   input  logic [32*N_REQ-1:0]  req_b,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 mul_start,
   output logic [31:0]          mul_a,
   output logic [31:0]          mul_b,
   input  logic                 mul_done,
   input  logic [31:0]          mul_c,
   input  logic                 mul_err,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_c,
   output logic                 rsp_err,
   output logic                 rsp_timeout
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   // WAIT gives up on the cycle the counter would reach TIMEOUT.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic            arm_q, arm_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [31:0]     mul_a_q, mul_a_d;
   logic [31:0]     mul_b_q, mul_b_d;
   logic            mul_start_q, mul_start_d;
   logic [7:0]      timer_q, timer_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [31:0]     rsp_c_q, rsp_c_d;
   logic            rsp_err_q, rsp_err_d;
   logic            rsp_timeout_q, rsp_timeout_d;

   logic [31:0]     a_arr [N_REQ];
   logic [31:0]     b_arr [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[32*i +: 32];
      assign b_arr[i] = req_b[32*i +: 32];
   end

   // Round-robin search: first valid requester at or after the pointer, wrapping.
   logic            gnt_found;
   logic [IDW-1:0]  gnt_idx, gnt_next, cand;

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gnt_next  = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDW'((int'(ptr_q) + k) % N_REQ);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
            gnt_next  = IDW'((int'(ptr_q) + k + 1) % N_REQ);
         end
      end
   end

   // arm_q holds off grants for the first cycle after reset release, which keeps
   // req_ready low while in reset and mul_start low on the cycle after release.
   logic grant;
   assign grant     = arm_q && (state_q == IDLE) && gnt_found;
   assign req_ready = grant ? (N_REQ'(1) << gnt_idx) : '0;

   always_comb begin
      state_d       = state_q;
      arm_d         = 1'b1;
      ptr_d         = ptr_q;
      id_d          = id_q;
      mul_a_d       = mul_a_q;
      mul_b_d       = mul_b_q;
      mul_start_d   = 1'b0;
      timer_d       = timer_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_c_d       = rsp_c_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               mul_a_d     = a_arr[gnt_idx];
               mul_b_d     = b_arr[gnt_idx];
               id_d        = gnt_idx;
               ptr_d       = gnt_next;
               mul_start_d = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = 8'd0;
            state_d = WAIT;
         end
         WAIT: begin
            timer_d = timer_q + 8'd1;
            // A done in the timeout cycle still counts as a real result.
            if (mul_done) begin
               rsp_c_d       = mul_c;
               rsp_err_d     = mul_err;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else if (timer_q == TMO_LAST) begin
               rsp_c_d       = 32'd0;
               rsp_err_d     = 1'b0;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         arm_q         <= 1'b0;
         ptr_q         <= '0;
         id_q          <= '0;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         mul_start_q   <= 1'b0;
         timer_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_c_q       <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         arm_q         <= arm_d;
         ptr_q         <= ptr_d;
         id_q          <= id_d;
         mul_a_q       <= mul_a_d;
         mul_b_q       <= mul_b_d;
         mul_start_q   <= mul_start_d;
         timer_q       <= timer_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_c_q       <= rsp_c_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign mul_start   = mul_start_q;
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = id_q;
   assign rsp_c       = rsp_c_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_fmul_share_ctrl.sv
// tb/tb_fmul_share_ctrl.sv - scoreboard bench for fmul_share_ctrl with a latency-programmable multiplier model
//
// Purpose: drives directed operand requests, models the multiplier, and checks responses
// popped from an expected-response queue by an independent monitor.
// Ports: none (top-level bench).

module tb_fmul_share_ctrl;

   localparam int N   = 4;
   localparam int TMO = 8;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [32*N-1:0] req_a, req_b;
   logic [N-1:0]    req_ready;
   logic            mul_start;
   logic [31:0]     mul_a, mul_b;
   logic            mul_done;
   logic [31:0]     mul_c;
   logic            mul_err;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [31:0]     rsp_c;
   logic            rsp_err;
   logic            rsp_timeout;

   fmul_share_ctrl #(.N_REQ(N), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_done(mul_done), .mul_c(mul_c), .mul_err(mul_err),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_c(rsp_c), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] c;
      logic        err;
      logic        tmo;
   } exp_t;

   exp_t sb[$];
   int   glog[$];
   int   total = 0;
   int   bad   = 0;
   int   mdl_lat = 0;
   logic stray_req = 1'b0;
   exp_t mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int id, input logic [31:0] c, input logic err, input logic tmo);
      exp_t e;
      e.id  = 2'(id);
      e.c   = c;
      e.err = err;
      e.tmo = tmo;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(sb.size()), 0);
   endtask

   // Hand-computed products for the operand pairs used below.
   function automatic logic [32:0] prod(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40400000 && b == 32'h40000000) return {1'b0, 32'h40C00000};
      if (a == 32'h3FC00000 && b == 32'h3FC00000) return {1'b0, 32'h40100000};
      if (a == 32'h40000000 && b == 32'h40000000) return {1'b0, 32'h40800000};
      if (a == 32'h7F000000 && b == 32'h7F000000) return {1'b1, 32'h7F800000};
      return 33'd0;
   endfunction

   // Multiplier model: done L cycles after the start cycle; lat 0 means never.
   initial begin : mul_model
      logic [31:0] ca, cb;
      logic [32:0] r;
      int          lat;
      bit          abort;
      mul_done = 1'b0;
      mul_c    = '0;
      mul_err  = 1'b0;
      forever begin
         @(negedge clk);
         if (stray_req) begin
            @(posedge clk); #1;
            mul_done = 1'b1; mul_c = 32'hDEADBEEF; mul_err = 1'b1;
            @(posedge clk); #1;
            mul_done = 1'b0; mul_c = '0; mul_err = 1'b0;
            stray_req = 1'b0;
         end else if (rst_n && mul_start && mdl_lat > 0) begin
            ca = mul_a; cb = mul_b; lat = mdl_lat; abort = 1'b0;
            for (int i = 0; i < lat; i++) begin
               @(posedge clk);
               if (!rst_n) abort = 1'b1;
            end
            if (!abort) begin
               #1;
               chk("mul_a_held", 64'(mul_a), 64'(ca));
               chk("mul_b_held", 64'(mul_b), 64'(cb));
               r = prod(ca, cb);
               mul_done = 1'b1; mul_c = r[31:0]; mul_err = r[32];
               @(posedge clk); #1;
               mul_done = 1'b0; mul_c = '0; mul_err = 1'b0;
            end
         end
      end
   end

   // Response monitor: pops the scoreboard on every response handshake.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got id=%0d c=%h, want no response", rsp_id, rsp_c);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
            chk("rsp_c", 64'(rsp_c), 64'(mon_e.c));
            chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.tmo));
         end
      end
   end

   // Grant monitor: ready must be one-hot and only toward a valid requester.
   always @(negedge clk) begin
      if (rst_n && req_ready != '0) begin
         chk("rdy_onehot", ($onehot(req_ready) && ((req_ready & ~req_valid) == '0)) ? 64'd1 : 64'd0, 64'd1);
         for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
      end
   end

   task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int exp_lat, input int hold,
                         input logic [31:0] exp_c, input logic exp_err, input logic exp_tmo);
      int n;
      int oth;
      logic [63:0] snap;
      oth = (id + 1) % N;
      push_exp(id, exp_c, exp_err, exp_tmo);
      mdl_lat = lat;
      @(posedge clk); #1;
      req_a[32*id +: 32] = a;
      req_b[32*id +: 32] = b;
      req_valid[id] = 1'b1;
      rsp_ready = (hold == 0);
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready[id] && n < 50);
      chk("accept_ready", 64'(req_ready), 64'(1) << id);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      @(negedge clk);
      chk("start_high", 64'(mul_start), 1);
      @(negedge clk);
      chk("start_low", 64'(mul_start), 0);
      n = 2;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
      chk("rsp_latency", 64'(n), 64'(exp_lat));
      if (hold > 0) begin
         snap = 64'({rsp_valid, rsp_id, rsp_c, rsp_err, rsp_timeout});
         req_valid[oth] = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_stable", 64'({rsp_valid, rsp_id, rsp_c, rsp_err, rsp_timeout}), snap);
            chk("bp_no_ready", 64'(req_ready), 0);
            chk("bp_no_start", 64'(mul_start), 0);
         end
         @(posedge clk); #1;
         rsp_ready = 1'b1;
         req_valid[oth] = 1'b0;
      end
      drain("rsp_drain");
      @(negedge clk);
      chk("rsp_cleared", 64'(rsp_valid), 0);
   endtask

   initial begin : stim
      int n;
      int rr_exp[5];
      rr_exp = '{0, 1, 2, 3, 0};
      rst_n = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_operands", 64'({mul_a, mul_b}), 0);
      chk("reset_ctrl", 64'({req_ready, mul_start, rsp_valid, rsp_id, rsp_err, rsp_timeout, rsp_c}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_no_start", 64'(mul_start), 0);

      // Round-robin with all requesters continuously valid.
      glog.delete();
      mdl_lat = 2;
      for (int i = 0; i < 5; i++) push_exp(rr_exp[i], 32'h40100000, 1'b0, 1'b0);
      @(posedge clk); #1;
      req_a = {N{32'h3FC00000}};
      req_b = {N{32'h3FC00000}};
      req_valid = '1;
      n = 0;
      while (glog.size() < 5 && n < 300) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      req_valid = '0;
      chk("rr_grant_count", 64'(glog.size()), 5);
      for (int i = 0; i < 5; i++)
         if (i < glog.size()) chk("rr_order", 64'(glog[i]), 64'(rr_exp[i]));
      drain("rr_drain");
      repeat (2) @(negedge clk);

      // Single op through a wrapped pointer, L=4.
      run_op(0, 32'h40400000, 32'h40000000, 4, 6, 0, 32'h40C00000, 1'b0, 1'b0);
      // Backpressure for 10 cycles while another requester waits.
      run_op(2, 32'h40000000, 32'h40000000, 2, 4, 10, 32'h40800000, 1'b0, 1'b0);
      // Timeout: multiplier never finishes.
      run_op(1, 32'h40400000, 32'h40000000, 0, TMO + 2, 0, 32'h0, 1'b0, 1'b1);
      // Stray done in IDLE must not produce a response.
      stray_req = 1'b1;
      n = 0;
      while (stray_req && n < 20) begin @(negedge clk); n++; end
      repeat (2) begin
         @(negedge clk);
         chk("stray_no_rsp", 64'(rsp_valid), 0);
      end
      // Minimum latency op after the stray done.
      run_op(3, 32'h3FC00000, 32'h3FC00000, 1, 3, 0, 32'h40100000, 1'b0, 1'b0);
      // Overflow flag passthrough.
      run_op(1, 32'h7F000000, 32'h7F000000, 3, 5, 0, 32'h7F800000, 1'b1, 1'b0);

      // Reset during WAIT; pointer would favour requester 2 if not cleared.
      mdl_lat = 5;
      @(posedge clk); #1;
      req_a[32 +: 32] = 32'h40400000;
      req_b[32 +: 32] = 32'h40000000;
      req_valid[1] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready[1] && n < 50);
      chk("rst_op_accept", 64'(req_ready), 64'b0010);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (3) @(negedge clk);
      chk("rst_pre_operand", 64'(mul_a), 64'h40400000);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_operands", 64'({mul_a, mul_b}), 0);
      chk("rst_mid_ctrl", 64'({req_ready, mul_start, rsp_valid, rsp_id, rsp_err, rsp_timeout, rsp_c}), 0);
      glog.delete();
      mdl_lat = 2;
      req_a[0 +: 32]  = 32'h40400000;
      req_b[0 +: 32]  = 32'h40000000;
      req_a[64 +: 32] = 32'h40400000;
      req_b[64 +: 32] = 32'h40000000;
      req_valid = 4'b0101;
      push_exp(0, 32'h40C00000, 1'b0, 1'b0);
      push_exp(2, 32'h40C00000, 1'b0, 1'b0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_hold_quiet", 64'({req_ready, mul_start}), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_no_start", 64'(mul_start), 0);
      n = 0;
      while (glog.size() < 2 && n < 100) begin
         @(negedge clk);
         n++;
         if (glog.size() > 0) begin
            @(posedge clk); #1;
            req_valid[glog[glog.size()-1]] = 1'b0;
         end
      end
      chk("rst_grant_count", 64'(glog.size()), 2);
      if (glog.size() > 0) chk("rst_first_grant", 64'(glog[0]), 0);
      if (glog.size() > 1) chk("rst_second_grant", 64'(glog[1]), 2);
      drain("rst_drain");

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fmul_share_ctrl.md
Name: fmul_share_ctrl

Overview:
Sequences a single shared multi-cycle single-precision float multiplier among N_REQ requesters. Each requester has a valid/ready operand handshake. Requests are granted round-robin and issued to the multiplier as a one-cycle start pulse. The controller waits for completion, or times out, and returns the result tagged with the requester ID over a valid/ready response channel. It sits between the client ports and the multiplier, so clients never observe the multiplier's busy behaviour.

Parameters:
N_REQ, 4, number of requesters (2..8); ID width IDW = clog2(N_REQ).
TIMEOUT, 63, max cycles in WAIT before the operation is aborted (1..255).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester operand valid
req_a  in  32*N_REQ  operand A, requester i at [32i+31:32i]
req_b  in  32*N_REQ  operand B, same packing
req_ready  out  N_REQ  per-requester accept (one-hot or zero)
mul_start  out  1  one-cycle start pulse to multiplier
mul_a  out  32  registered operand A to multiplier
mul_b  out  32  registered operand B to multiplier
mul_done  in  1  one-cycle completion pulse from multiplier
mul_c  in  32  multiplier result, valid with mul_done
mul_err  in  1  multiplier exponent overflow flag, valid with mul_done
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  requester index owning the response
rsp_c  out  32  result
rsp_err  out  1  copy of mul_err
rsp_timeout  out  1  operation aborted by timeout; rsp_c = 0

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; round-robin pointer = 0; timer = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first requester at or after the pointer, searching upward with wrap-around.
  - req_ready[g] is combinationally 1 in IDLE for the granted requester only. The handshake completes that cycle.
  - Capture req_a[g], req_b[g] into mul_a/mul_b and g into the ID register. Go to ISSUE.
  - Pointer becomes (g+1) mod N_REQ.
- ISSUE: mul_start = 1 for exactly one cycle. Clear the timer. Go to WAIT.
- WAIT:
  - Timer increments every cycle. mul_a/mul_b are held stable throughout.
  - On mul_done: capture mul_c and mul_err, set rsp_timeout = 0, go to RESP.
  - If the timer reaches TIMEOUT without mul_done: rsp_c = 0, rsp_err = 0, rsp_timeout = 1, go to RESP.
  - If mul_done arrives in the same cycle the timer hits TIMEOUT, mul_done wins.
- RESP:
  - rsp_valid = 1. rsp_id/rsp_c/rsp_err/rsp_timeout are held stable until rsp_valid && rsp_ready; then go to IDLE.
  - No new request is accepted during RESP (req_ready = 0), so at most one operation is outstanding.
- Latency, accept to rsp_valid: 2 + L cycles, where L is cycles from mul_start to mul_done. Minimum with L = 1 is 3.
- mul_done outside WAIT is ignored. A late done after a timeout must not corrupt the next operation.
- Fairness:
  - A requester holding req_valid waits at most N_REQ-1 other operations.
  - A requester may drop req_valid before it is granted; this is legal and it is simply skipped.
- Reset mid-operation returns immediately to IDLE with all outputs 0. mul_start is never asserted during or on the cycle after reset release.

Test Plan:
- Single op: requester 0 sends A=0x40400000, B=0x40000000; multiplier model L=4 → req_ready[0] 1 cycle; mul_start 1 cycle later; rsp_valid 6 cycles after accept with rsp_id=0, rsp_c=0x40C00000, rsp_err=0, rsp_timeout=0.
- Round-robin: all 4 requesters valid continuously, each A=B=0x3FC00000 → grants in order 0,1,2,3,0; each rsp_c=0x40100000; rsp_id sequence matches.
- Backpressure: rsp_ready held 0 for 10 cycles during RESP → rsp fields stable, req_ready all 0, mul_start never asserted; accepted in the cycle rsp_ready rises.
- Timeout: TIMEOUT=8, multiplier never asserts mul_done → rsp_valid 10 cycles after accept with rsp_timeout=1, rsp_c=0. A later stray mul_done in IDLE is ignored.
- Error passthrough: A=B=0x7F000000, model returns mul_err=1 → rsp_err=1 with the correct rsp_id.
- Reset mid-WAIT: rst_n low for 2 cycles during WAIT → all outputs 0 immediately; after release the first grant goes to requester 0 (pointer reset).
